// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction-memory req/ack read port plus the IF/ID register outputs.
// master = fetch stage, slave = memory/decode side; latency and backpressure are set by fetch_stage.
interface fetch_stage_if #(
    parameter int DATA_LEN    = 32,
    parameter int ADDRESS_LEN = 32
);
    logic                   imem_req;
    logic [ADDRESS_LEN-1:0] imem_addr;
    logic                   imem_ack;
    logic [DATA_LEN-1:0]    imem_rdata;
    logic                   if_valid;
    logic [ADDRESS_LEN-1:0] if_pc;
    logic [DATA_LEN-1:0]    if_instr;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues req/ack fetches, loads IF/ID; ack at N -> if_valid at N+1.
// freeze holds IF/ID and parks an in-flight word in a one-entry skid; branch_taken flushes.
// Optional perf counters (perf_fetched/perf_stall/perf_flush) under FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                     DATA_LEN    = 32,
    parameter int                     ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
    parameter int                     PC_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_flush,
`endif
    fetch_stage_if.master          bus
);
    localparam logic [ADDRESS_LEN-1:0] STEP = ADDRESS_LEN'(PC_STEP);

    typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [ADDRESS_LEN-1:0] pc_q, pc_d;
    logic                   if_valid_q, if_valid_d;
    logic [ADDRESS_LEN-1:0] if_pc_q, if_pc_d;
    logic [DATA_LEN-1:0]    if_instr_q, if_instr_d;
    // Skid occupancy is implied by S_HOLD, so it carries no separate valid bit.
    logic [ADDRESS_LEN-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_LEN-1:0]    skid_instr_q, skid_instr_d;
    logic [ADDRESS_LEN-1:0] pc_inc;
    logic                   load_vld;

    assign pc_inc = pc_q + STEP;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        load_vld     = 1'b0;
        if (branch_taken) begin
            pc_d       = branch_addr;
            if_valid_d = 1'b0;
            state_d    = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        pc_d = pc_inc;
                        if (!freeze) begin
                            if_instr_d = bus.imem_rdata;
                            if_pc_d    = pc_inc;
                            if_valid_d = 1'b1;
                            load_vld   = 1'b1;
                        end else begin
                            skid_instr_d = bus.imem_rdata;
                            skid_pc_d    = pc_inc;
                            state_d      = S_HOLD;
                        end
                    end else if (!freeze) begin
                        if_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_instr_d = skid_instr_q;
                        if_pc_d    = skid_pc_q;
                        if_valid_d = 1'b1;
                        load_vld   = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign bus.imem_req  = (state_q == S_REQ) && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, load_vld};
        perf_stall_d   = perf_stall_q + {31'd0, freeze};
        perf_flush_d   = perf_flush_q + {31'd0, branch_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
`else
    logic unused_load_vld;
    assign unused_load_vld = load_vld;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model (PC, IF/ID, skid kept as a queue).
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;

    fetch_stage_if #(.DATA_LEN(32), .ADDRESS_LEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

    fetch_stage #(.DATA_LEN(32), .ADDRESS_LEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
`endif
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } skid_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc, m_ifpc, m_ins;
    logic        m_vld;
    skid_t       m_skid[$];
    logic [31:0] m_fetched, m_stall, m_flush;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs as the spec's rules see them at the next rising edge.
    task automatic model_update(input bit r, input bit f, input bit b,
                                input logic [31:0] ba, input bit a, input logic [31:0] rd);
        skid_t s;
        if (r) begin
            m_pc = 32'h0; m_vld = 1'b0; m_ifpc = 32'h0; m_ins = 32'h0;
            m_skid.delete();
            m_fetched = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (f) m_stall++;
        if (b) begin
            m_flush++;
            m_pc = ba; m_vld = 1'b0;
            m_skid.delete();
        end else if (m_skid.size() == 0) begin
            if (a) begin
                if (!f) begin
                    m_ins = rd; m_ifpc = m_pc + 32'd4; m_vld = 1'b1; m_fetched++;
                end else begin
                    s.ins = rd; s.pc = m_pc + 32'd4;
                    m_skid.push_back(s);
                end
                m_pc = m_pc + 32'd4;
            end else if (!f) begin
                m_vld = 1'b0;
            end
        end else if (!f) begin
            s = m_skid.pop_front();
            m_ins = s.ins; m_ifpc = s.pc; m_vld = 1'b1; m_fetched++;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, (m_skid.size() == 0) && !rst});
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_vld});
        chk("if_pc", bus.if_pc, m_ifpc);
        chk("if_instr", bus.if_instr, m_ins);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
        chk("perf_flush", perf_flush, m_flush);
`endif
    endtask

    // Drive inputs away from the edge, advance the model, then check after the edge.
    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba, input bit a);
        logic [31:0] rd;
        rd = a ? mem(m_pc) : $urandom;
        rst = r; freeze = f; branch_taken = b; branch_addr = ba;
        bus.imem_ack = a; bus.imem_rdata = rd;
        model_update(r, f, b, ba, a, rd);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        m_pc = 0; m_ifpc = 0; m_ins = 0; m_vld = 0;
        m_fetched = 0; m_stall = 0; m_flush = 0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        @(negedge clk);

        // Reset with a stray ack: ack ignored, all IF/ID zero, request suppressed.
        step(1, 0, 0, 0, 1);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        // Streaming acks.
        step(0, 0, 0, 0, 1);
        chk("seq_ifpc0", bus.if_pc, 32'd4);
        chk("seq_addr0", bus.imem_addr, 32'd4);
        step(0, 0, 0, 0, 1);
        chk("seq_ifpc1", bus.if_pc, 32'd8);
        chk("seq_valid1", {31'd0, bus.if_valid}, 32'd1);

        // Ack at pc=8 under freeze, held 3 cycles, then released.
        step(0, 1, 0, 0, 1);
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        chk("hold_ifpc", bus.if_pc, 32'd8);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rel_instr", bus.if_instr, mem(32'd8));
        chk("rel_ifpc", bus.if_pc, 32'd12);
        chk("rel_addr", bus.imem_addr, 32'd12);
        chk("rel_req", {31'd0, bus.imem_req}, 32'd1);

        // Branch with a simultaneous ack, then branch while in HOLD.
        step(0, 0, 1, 32'h100, 1);
        chk("br_addr", bus.imem_addr, 32'h100);
        chk("br_valid", {31'd0, bus.if_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 0, 1, 32'h200, 0);
        chk("brhold_addr", bus.imem_addr, 32'h200);
        chk("brhold_req", {31'd0, bus.imem_req}, 32'd1);

        // Branch and freeze together: flush wins.
        step(0, 1, 1, 32'h300, 1);
        chk("brfrz_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("brfrz_addr", bus.imem_addr, 32'h300);

        // Two ack-less cycles: stable address, bubbles.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bub_addr", bus.imem_addr, 32'h300);
        chk("bub_valid", {31'd0, bus.if_valid}, 32'd0);

        // PC wrap.
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_ifpc", bus.if_pc, 32'h0);
        chk("wrap_instr", bus.if_instr, mem(32'hFFFF_FFFC));

        // Reset while in HOLD with a pending ack.
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("rsthold_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rsthold_ifpc", bus.if_pc, 32'h0);
        chk("rsthold_instr", bus.if_instr, 32'h0);
        chk("rsthold_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rsthold_perf", perf_fetched | perf_stall | perf_flush, 32'h0);
`endif
        step(0, 0, 0, 0, 0);
        chk("rsthold_req", {31'd0, bus.imem_req}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit          r, f, b, a;
            logic [31:0] ba;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 15) == 0);
            a  = ($urandom_range(0, 2) != 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : $urandom;
            step(r, f, b, ba, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
